// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, the fetch
// FSM state encoding, and the default no-op instruction.
package if_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding at pc
        ST_HOLD  = 2'd1,  // word parked in skid buffer, waiting for freeze to drop
        ST_DRAIN = 2'd2   // stale request must finish before fetching the redirect target
    } fetch_state_e;

    // Word-aligned increment; wraps modulo 2^32 naturally.
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake. The fetch stage is the master;
// the memory (or a bench model of it) is the slave.
interface if_stage_if;
    import if_stage_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ready;
    logic [WORD_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds PC+4, the instruction word and a valid flag.
// Flush beats load beats bubble; with none asserted everything holds.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_instr,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_instr,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic              r_valid;

    // Register update: reset/flush inject a NOP, load captures, bubble clears valid only.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake, parks a
// word in a one-entry skid buffer when decode is frozen, and handles execute
// redirects (including draining a request that was already in flight).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_address,
    if_stage_if.master        imem,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] Instruction,
    output logic              valid
);

    fetch_state_e      r_state;
    logic [WORD_W-1:0] r_pc;        // next fetch address (redirect target while draining)
    logic [WORD_W-1:0] r_addr;      // address of the outstanding request
    logic [WORD_W-1:0] r_skid_pc;
    logic [WORD_W-1:0] r_skid_instr;

    logic [WORD_W-1:0] w_pc_inc;
    logic [WORD_W-1:0] w_target;
    logic              w_accept;
    logic              w_load;
    logic              w_bubble;
    logic [WORD_W-1:0] w_ld_pc;
    logic [WORD_W-1:0] w_ld_instr;

    assign w_pc_inc = pc_plus4(r_pc);
    assign w_target = word_align(branch_address);
    assign w_accept = (r_state == ST_FETCH) && imem.imem_ready;

    // Request is a decode of state; forced low while reset is asserted so a
    // mid-handshake reset withdraws it immediately.
    assign imem.imem_req  = !rst && (r_state != ST_HOLD);
    assign imem.imem_addr = r_addr;

    // Fetch FSM, PC, request address and skid buffer. Redirect wins over
    // freeze and ready; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= word_align(RESET_PC);
            r_addr       <= word_align(RESET_PC);
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else if (branch_taken) begin
            r_pc <= w_target;
            case (r_state)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        r_state <= ST_FETCH;
                        r_addr  <= w_target;
                    end else begin
                        // keep r_addr: the in-flight request finishes at its old address
                        r_state <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    r_state <= ST_FETCH;
                    r_addr  <= w_target;
                end
                default: r_state <= ST_DRAIN;
            endcase
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        r_pc   <= w_pc_inc;
                        r_addr <= w_pc_inc;
                        if (freeze) begin
                            r_skid_pc    <= w_pc_inc;
                            r_skid_instr <= imem.imem_rdata;
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!freeze)
                        r_state <= ST_FETCH;
                end
                ST_DRAIN: begin
                    if (imem.imem_ready) begin
                        r_state <= ST_FETCH;
                        r_addr  <= r_pc;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // IF/ID control: load from memory or from the skid buffer; bubble when
    // FETCH gets no word and decode is free to move on.
    always_comb begin
        w_load     = 1'b0;
        w_bubble   = 1'b0;
        w_ld_pc    = w_pc_inc;
        w_ld_instr = imem.imem_rdata;
        if (!branch_taken) begin
            if (r_state == ST_HOLD) begin
                w_load     = !freeze;
                w_ld_pc    = r_skid_pc;
                w_ld_instr = r_skid_instr;
            end else if (r_state == ST_FETCH) begin
                w_load   = w_accept && !freeze;
                w_bubble = !imem.imem_ready && !freeze;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (branch_taken),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_pc     (w_ld_pc),
        .i_instr  (w_ld_instr),
        .o_pc     (PC),
        .o_instr  (Instruction),
        .o_valid  (valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory responses are driven per scenario,
// expected IF/ID contents are queued as stimulus is issued and popped by a
// monitor whenever a new instruction lands in IF/ID.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem           (imem.master),
        .PC             (PC),
        .Instruction    (Instruction),
        .valid          (valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory response at the expected address; optionally queue the IF/ID result.
    task automatic serve(input logic [31:0] a, input bit exp_load);
        chk("req", {63'd0, imem.imem_req}, 64'd1);
        chk("addr", {32'd0, imem.imem_addr}, {32'd0, a});
        if (exp_load) sb_q.push_back({a + 32'd4, word(a)});
        imem.imem_ready = 1'b1;
        imem.imem_rdata = word(a);
        tick();
        imem.imem_ready = 1'b0;
    endtask

    // Monitor: a new IF/ID entry is valid=1 with contents differing from the previous cycle.
    logic        m_vld = 1'b0;
    logic [63:0] m_prev = '0;
    always @(negedge clk) begin
        if (valid === 1'b1 && (!m_vld || {PC, Instruction} !== m_prev)) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 64'(sb_q.size()), 64'd1);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", {32'd0, PC}, {32'd0, e[63:32]});
                chk("sb_instr", {32'd0, Instruction}, {32'd0, e[31:0]});
            end
        end
        m_vld  <= (valid === 1'b1);
        m_prev <= {PC, Instruction};
    end

    task automatic chk_flushed(input string tag);
        chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
        chk({tag, "_pc"}, {32'd0, PC}, 64'd0);
        chk({tag, "_instr"}, {32'd0, Instruction}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
        tick(); tick();
        // reset state
        chk_flushed("rst");
        chk("rst_req", {63'd0, imem.imem_req}, 64'd0);
        chk("rst_addr", {32'd0, imem.imem_addr}, 64'd0);

        // back-to-back fetch
        rst = 1'b0; #1;
        chk("first_valid", {63'd0, valid}, 64'd0);
        serve(32'h0, 1'b1);
        chk("lat_valid", {63'd0, valid}, 64'd1);
        serve(32'h4, 1'b1);
        serve(32'h8, 1'b1);
        tick();
        chk("bubble_valid", {63'd0, valid}, 64'd0);
        serve(32'hC, 1'b1);

        // freeze with ready on the first frozen cycle
        freeze = 1'b1;
        imem.imem_ready = 1'b1; imem.imem_rdata = word(32'h10);
        tick();
        imem.imem_ready = 1'b0;
        chk("hold_req", {63'd0, imem.imem_req}, 64'd0);
        chk("hold_pc", {32'd0, PC}, 64'h10);
        chk("hold_instr", {32'd0, Instruction}, {32'd0, word(32'hC)});
        chk("hold_valid", {63'd0, valid}, 64'd1);
        tick();
        chk("hold2_req", {63'd0, imem.imem_req}, 64'd0);
        tick();
        chk("hold3_pc", {32'd0, PC}, 64'h10);
        freeze = 1'b0;
        sb_q.push_back({32'h14, word(32'h10)});
        tick();
        chk("resume_valid", {63'd0, valid}, 64'd1);

        // freeze without ready: IF/ID and request untouched
        freeze = 1'b1;
        tick();
        chk("frz_valid", {63'd0, valid}, 64'd1);
        chk("frz_pc", {32'd0, PC}, 64'h14);
        chk("frz_req", {63'd0, imem.imem_req}, 64'd1);
        chk("frz_addr", {32'd0, imem.imem_addr}, 64'h14);
        freeze = 1'b0;
        serve(32'h14, 1'b1);

        // redirect while a request waits: drain at old address
        branch_taken = 1'b1; branch_address = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        chk_flushed("br");
        for (int i = 0; i < 3; i++) begin
            chk("drain_addr", {32'd0, imem.imem_addr}, 64'h18);
            chk("drain_req", {63'd0, imem.imem_req}, 64'd1);
            tick();
        end
        serve(32'h18, 1'b0);
        chk("drain_discard", {63'd0, valid}, 64'd0);
        serve(32'h100, 1'b1);

        // redirect + ready + freeze in one cycle
        branch_taken = 1'b1; branch_address = 32'h200; freeze = 1'b1;
        imem.imem_ready = 1'b1; imem.imem_rdata = word(32'h104);
        tick();
        branch_taken = 1'b0; freeze = 1'b0; imem.imem_ready = 1'b0;
        chk_flushed("brrdy");
        serve(32'h200, 1'b1);

        // pc wrap
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFE;
        imem.imem_ready = 1'b1; imem.imem_rdata = word(32'h204);
        tick();
        branch_taken = 1'b0; imem.imem_ready = 1'b0;
        serve(32'hFFFF_FFFC, 1'b1);
        chk("wrap_pc", {32'd0, PC}, 64'd0);
        serve(32'h0, 1'b1);

        // reset while draining a redirect; ready in the reset cycle is dropped
        branch_taken = 1'b1; branch_address = 32'h300;
        tick();
        branch_taken = 1'b0;
        chk("pre_rst_addr", {32'd0, imem.imem_addr}, 64'h4);
        rst = 1'b1;
        imem.imem_ready = 1'b1; imem.imem_rdata = word(32'h4);
        tick();
        imem.imem_ready = 1'b0;
        chk_flushed("mrst");
        chk("mrst_req", {63'd0, imem.imem_req}, 64'd0);
        rst = 1'b0; #1;
        serve(32'h0, 1'b1);

        tick(); tick();
        chk("sb_left", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
